// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared encodings for the 16-bit register-transfer bus.
//               Source and destination codes are also used by the bus
//               driver mux and the control unit. Also holds the transfer
//               sequencer state encoding and the default bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_WIDTH = 16;

    // Bus source codes (select which unit drives the bus)
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_REG = 2'd2;
    localparam logic [1:0] SRC_CTL = 2'd3;

    // Bus destination codes; values above DST_PC are illegal
    localparam logic [2:0] DST_NONE = 3'd0;
    localparam logic [2:0] DST_IR   = 3'd1;
    localparam logic [2:0] DST_MAR  = 3'd2;
    localparam logic [2:0] DST_MEM  = 3'd3;
    localparam logic [2:0] DST_REG  = 3'd4;
    localparam logic [2:0] DST_PC   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } xfer_state_t;

    function automatic logic dst_is_illegal(input logic [2:0] code);
        return (code > DST_PC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dst_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_dst_decode
// Description : Decodes a 3-bit bus destination code into one-hot load
//               strobes. Strobes fire only while strobe_en is high; the
//               illegal flag is independent of strobe_en.
// Ports       : code      in  3  destination code
//               strobe_en in  1  allow a load strobe this cycle
//               ld_ir/ld_mar/ld_mem/ld_reg/ld_pc  out  1 each  load strobes
//               illegal   out 1  code is not a defined destination
// Revision    : 1.0 - initial release
// ============================================================================
module bus_dst_decode
    import bus_pkg::*;
(
    input  logic [2:0] code,
    input  logic       strobe_en,
    output logic       ld_ir,
    output logic       ld_mar,
    output logic       ld_mem,
    output logic       ld_reg,
    output logic       ld_pc,
    output logic       illegal
);

    always_comb begin
        ld_ir   = 1'b0;
        ld_mar  = 1'b0;
        ld_mem  = 1'b0;
        ld_reg  = 1'b0;
        ld_pc   = 1'b0;
        illegal = dst_is_illegal(code);
        if (strobe_en) begin
            case (code)
                DST_IR:  ld_ir  = 1'b1;
                DST_MAR: ld_mar = 1'b1;
                DST_MEM: ld_mem = 1'b1;
                DST_REG: ld_reg = 1'b1;
                DST_PC:  ld_pc  = 1'b1;
                default: ;  // capture-only and illegal codes load nothing
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_xfer.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer
// Description : Register-transfer sequencer. Accepts one src/dst request,
//               enables exactly one bus source, pulses the destination load
//               strobe on the completion cycle, captures the bus value and
//               reports done or err. Memory sources may insert wait states,
//               bounded by MEM_TIMEOUT.
// Ports       : clk, rst (sync, active-low)
//               req_valid/req_ready, req_src[1:0], req_dst[2:0]  request
//               mem_ready                       memory output valid
//               bus_in[WIDTH-1:0]               resolved bus value
//               alu/mem/reg/ctl_out_en          one-hot source enables
//               ld_ir/mar/mem/reg/pc            destination load strobes
//               data[WIDTH-1:0]                 last transferred value
//               done, err                       one-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer
    import bus_pkg::*;
#(
    parameter int WIDTH       = BUS_WIDTH,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_src,
    input  logic [2:0]       req_dst,
    output logic             req_ready,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] bus_in,
    output logic             alu_out_en,
    output logic             mem_out_en,
    output logic             reg_out_en,
    output logic             ctl_out_en,
    output logic             ld_ir,
    output logic             ld_mar,
    output logic             ld_mem,
    output logic             ld_reg,
    output logic             ld_pc,
    output logic [WIDTH-1:0] data,
    output logic             done,
    output logic             err
);

    localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MEM_TIMEOUT - 1);

    xfer_state_t        r_state;
    xfer_state_t        w_next_state;
    logic [1:0]         r_src;
    logic [2:0]         r_dst;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               w_complete;
    logic               w_drive;
    logic [2:0]         w_dec_code;
    logic               w_dec_illegal;

    // One decoder serves both jobs: in IDLE it screens the incoming code,
    // elsewhere it decodes the latched code for the load strobe.
    assign w_dec_code = (r_state == ST_IDLE) ? req_dst : r_dst;

    bus_dst_decode u_dst_decode (
        .code      (w_dec_code),
        .strobe_en (w_complete),
        .ld_ir     (ld_ir),
        .ld_mar    (ld_mar),
        .ld_mem    (ld_mem),
        .ld_reg    (ld_reg),
        .ld_pc     (ld_pc),
        .illegal   (w_dec_illegal)
    );

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_dec_illegal ? ST_ERR : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if ((r_src != SRC_MEM) || mem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_wait_cnt == c_wait_last) begin
                    // this is the MEM_TIMEOUT-th consecutive not-ready cycle
                    w_next_state = ST_ERR;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_drive    = (r_state == ST_DRIVE);
    assign alu_out_en = w_drive && (r_src == SRC_ALU);
    assign mem_out_en = w_drive && (r_src == SRC_MEM);
    assign reg_out_en = w_drive && (r_src == SRC_REG);
    assign ctl_out_en = w_drive && (r_src == SRC_CTL);
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERR);
    assign data       = r_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_src      <= SRC_ALU;
            r_dst      <= DST_NONE;
            r_wait_cnt <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && req_valid) begin
                r_src      <= req_src;
                r_dst      <= req_dst;
                r_wait_cnt <= '0;
            end else if (w_drive && !w_complete) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else if (r_state == ST_ERR) begin
                r_wait_cnt <= '0;
            end
            if (w_complete) begin
                r_data <= bus_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xfer
// Description : Scoreboard bench for bus_xfer. The driver pushes one
//               transaction-level expectation per accepted request; the
//               monitor accumulates per-transfer activity and pops/compares
//               on every done or err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer;
    import bus_pkg::*;

    localparam int WIDTH       = 16;
    localparam int MEM_TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic [1:0]       req_src = 2'd0;
    logic [2:0]       req_dst = 3'd0;
    logic             req_ready;
    logic             mem_ready = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;
    logic alu_out_en, mem_out_en, reg_out_en, ctl_out_en;
    logic ld_ir, ld_mar, ld_mem, ld_reg, ld_pc;
    logic [WIDTH-1:0] data;
    logic done, err;

    bus_xfer #(.WIDTH(WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src),
        .req_dst(req_dst), .req_ready(req_ready), .mem_ready(mem_ready),
        .bus_in(bus_in), .alu_out_en(alu_out_en), .mem_out_en(mem_out_en),
        .reg_out_en(reg_out_en), .ctl_out_en(ctl_out_en), .ld_ir(ld_ir),
        .ld_mar(ld_mar), .ld_mem(ld_mem), .ld_reg(ld_reg), .ld_pc(ld_pc),
        .data(data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          en_cycles;
        logic [3:0]  en_mask;   // {ctl,reg,mem,alu}
        logic [4:0]  ld_mask;   // {pc,reg,mem,mar,ir}
        int          lat;       // cycles from handshake cycle to done/err
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] ref_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome derived from the request and
    // the number of memory wait cycles k the driver will apply.
    function automatic exp_t model(input logic [1:0] s, input logic [2:0] d,
                                   input int k, input logic [15:0] v);
        exp_t e;
        int   waits;
        e.en_mask = '0;
        e.ld_mask = '0;
        waits     = (s == SRC_MEM) ? k : 0;
        if (d >= 3'd6) begin
            e.is_err = 1'b1; e.en_cycles = 0; e.lat = 1; e.data = ref_data;
        end else if (waits >= MEM_TIMEOUT) begin
            e.is_err = 1'b1; e.en_cycles = MEM_TIMEOUT; e.en_mask = 4'b1 << s;
            e.lat = MEM_TIMEOUT + 1; e.data = ref_data;
        end else begin
            e.is_err = 1'b0; e.en_cycles = waits + 1; e.en_mask = 4'b1 << s;
            e.ld_mask = (d == 3'd0) ? 5'b0 : (5'b1 << (d - 3'd1));
            e.lat = waits + 2; e.data = v;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         hs_cyc = 0;
    int         en_cnt = 0;
    logic [3:0] en_acc = '0;
    logic [4:0] ld_acc = '0;
    logic       rst_prev = 1'b1;

    always @(negedge clk) begin
        logic [3:0] en_now;
        logic [4:0] ld_now;
        exp_t       e;
        cyc++;
        en_now = {ctl_out_en, reg_out_en, mem_out_en, alu_out_en};
        ld_now = {ld_pc, ld_reg, ld_mem, ld_mar, ld_ir};
        if (!rst) begin
            if (!rst_prev) begin
                check("reset_state", {4'b0, en_now, ld_now, done, err, req_ready, data},
                      {4'b0, 4'b0, 5'b0, 1'b0, 1'b0, 1'b1, 16'h0});
            end
            exp_q.delete();
            en_cnt = 0; en_acc = '0; ld_acc = '0;
        end else begin
            checks++;
            if (($countones(en_now) > 1) || ($countones(ld_now) > 1) ||
                ((ld_now != 0) && (en_now == 0)) || (done && err)) begin
                failures++;
                $display("FAIL invariant: en=%b ld=%b done=%b err=%b", en_now, ld_now, done, err);
            end
            en_cnt += (en_now != 0) ? 1 : 0;
            en_acc |= en_now;
            ld_acc |= ld_now;
            if (req_valid && req_ready) hs_cyc = cyc;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_status: done=%b err=%b with no pending transfer", done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("status_err",  {31'b0, err}, {31'b0, e.is_err});
                    check("data",        {16'b0, data}, {16'b0, e.data});
                    check("en_cycles",   en_cnt, e.en_cycles);
                    check("en_mask",     {28'b0, en_acc}, {28'b0, e.en_mask});
                    check("ld_mask",     {27'b0, ld_acc}, {27'b0, e.ld_mask});
                    check("latency",     cyc - hs_cyc, e.lat);
                end
                en_cnt = 0; en_acc = '0; ld_acc = '0;
            end
        end
        rst_prev = rst;
    end

    // ---------------- driver ----------------
    task automatic wait_hs(output bit ok);
        int guard = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!req_ready) begin
            guard++;
            if (guard > 50) begin
                checks++; failures++;
                $display("FAIL handshake_timeout: req_ready=%b required 1", req_ready);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic [1:0] s, input logic [2:0] d, input int k, input logic [15:0] v);
        bit   ok;
        exp_t e;
        req_valid = 1'b1; req_src = s; req_dst = d;
        bus_in = 16'($urandom); mem_ready = 1'($urandom);
        wait_hs(ok);
        if (!ok) begin req_valid = 1'b0; return; end
        e = model(s, d, k, v);
        exp_q.push_back(e);
        if (!e.is_err) ref_data = v;
        // junk on the request lines must be ignored outside the handshake
        req_valid = 1'b0; req_src = 2'($urandom); req_dst = 3'($urandom);
        if (d < 3'd6) begin
            if (s == SRC_MEM) begin
                for (int i = 0; i < k && i < MEM_TIMEOUT; i++) begin
                    mem_ready = 1'b0; bus_in = 16'($urandom);
                    @(posedge clk); #1;
                end
            end
            if (!(s == SRC_MEM && k >= MEM_TIMEOUT)) begin
                mem_ready = (s == SRC_MEM) ? 1'b1 : 1'($urandom);
                bus_in = v;
                @(posedge clk); #1;
            end
        end
        bus_in = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [1:0]  s;
        logic [2:0]  d;
        int          k;
        int          guard;

        // reset held with a pending request: nothing may be accepted
        rst = 1'b0; req_valid = 1'b1; req_src = SRC_ALU; req_dst = DST_IR;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        xfer(SRC_ALU, DST_IR, 0, 16'hBEEF);
        xfer(SRC_MEM, DST_REG, 3, 16'h1234);
        xfer(SRC_MEM, DST_MAR, MEM_TIMEOUT, 16'hDEAD);
        xfer(SRC_CTL, 3'd7, 0, 16'h5555);
        xfer(SRC_REG, DST_NONE, 0, 16'hA5A5);
        xfer(SRC_MEM, DST_MEM, MEM_TIMEOUT - 1, 16'h0F0F);

        for (int n = 0; n < 40; n++) begin
            s = 2'($urandom_range(3, 0));
            d = 3'($urandom_range(7, 0));
            k = (s == SRC_MEM) ? int'($urandom_range(MEM_TIMEOUT, 0)) : 0;
            xfer(s, d, k, 16'($urandom));
            if ($urandom_range(2, 0) == 0) begin
                repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
            end
        end

        // back-to-back reg->pc with reset during DRIVE of the second
        xfer(SRC_REG, DST_PC, 0, 16'h7001);
        req_valid = 1'b1; req_src = SRC_REG; req_dst = DST_PC; bus_in = 16'h7002;
        wait_hs(ok);
        if (ok) begin
            exp_q.push_back(model(SRC_REG, DST_PC, 0, 16'h7002));
            rst = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b1;
            ref_data = '0;
        end
        xfer(SRC_REG, DST_PC, 0, 16'h7003);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk); guard++;
        end
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
